// File: rtl/hyper_target_pkg.sv
// Shared types for the HyperRAM target emulator: command/address layout and FSM states.
package hyper_target_pkg;

    typedef struct packed {
        logic        rw;     // 1 = read
        logic        as;     // 1 = register space
        logic        burst;
        logic [28:0] row;
        logic [12:0] rsvd;
        logic [2:0]  col;
    } ca_t;

    typedef enum logic [2:0] {
        IDLE,
        CA,
        LATENCY,
        WR_DATA,
        RD_DATA,
        REG_WR,
        WAIT_CSN
    } state_e;

    localparam int CA_BYTES = 6;
    localparam int ID_ADDR  = 0;

endpackage

// File: rtl/hyper_target_sync.sv
// Brings the host-driven bus into clk_i: one shared 2-flop synchronizer keeps ck/csn/dq/rwds aligned.
module hyper_target_sync (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ck_i,
    input  logic       csn_i,
    input  logic [7:0] dq_i,
    input  logic       rwds_i,
    output logic       edge_o,
    output logic       rising_o,
    output logic       csn_s_o,
    output logic [7:0] dq_s_o,
    output logic       rwds_s_o
);

    // {ck, csn, rwds, dq}; csn idles high
    localparam logic [10:0] SYNC_RST = 11'h200;

    logic [10:0] meta_q, sync_q;
    logic        ck_prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q    <= SYNC_RST;
            sync_q    <= SYNC_RST;
            ck_prev_q <= 1'b0;
        end else begin
            meta_q    <= {ck_i, csn_i, rwds_i, dq_i};
            sync_q    <= meta_q;
            ck_prev_q <= sync_q[10];
        end
    end

    assign edge_o   = sync_q[10] ^ ck_prev_q;
    assign rising_o = sync_q[10] & ~ck_prev_q;
    assign csn_s_o  = sync_q[9];
    assign rwds_s_o = sync_q[8];
    assign dq_s_o   = sync_q[7:0];

endmodule

// File: rtl/hyper_target_emu.sv
// HyperBus target emulating a HyperRAM: decodes CA, applies fixed 2x latency, serves linear bursts from a word memory.
module hyper_target_emu
    import hyper_target_pkg::*;
#(
    parameter int unsigned AddrWidth      = 10,
    parameter int unsigned InitialLatency = 6,
    parameter logic [15:0] IdReg0         = 16'h0C81
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       hyper_reset_ni,
    input  logic       hyper_ck_i,
    input  logic       hyper_csn_i,
    input  logic [7:0] hyper_dq_i,
    output logic [7:0] hyper_dq_o,
    output logic       hyper_dq_oe_o,
    input  logic       hyper_rwds_i,
    output logic       hyper_rwds_o,
    output logic       hyper_rwds_oe_o
);

    localparam logic [4:0] LAT_LAST = 5'(2 * InitialLatency - 1);
    localparam logic [4:0] CA_LAST  = 5'(CA_BYTES - 1);

    logic arst;
    logic edge_s, rising_s, csn_s, rwds_s;
    logic [7:0] dq_s;

    // Bus reset behaves like rst_i for control state; memory has no reset either way.
    assign arst = rst_i | ~hyper_reset_ni;

    hyper_target_sync u_sync (
        .clk_i   (clk_i),
        .rst_i   (arst),
        .ck_i    (hyper_ck_i),
        .csn_i   (hyper_csn_i),
        .dq_i    (hyper_dq_i),
        .rwds_i  (hyper_rwds_i),
        .edge_o  (edge_s),
        .rising_o(rising_s),
        .csn_s_o (csn_s),
        .dq_s_o  (dq_s),
        .rwds_s_o(rwds_s)
    );

    state_e               state_q, state_d;
    ca_t                  ca_q, ca_d, ca_next;
    logic [4:0]           cnt_q, cnt_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic                 lo_q, lo_d;
    logic [7:0]           whi_q, whi_d;
    logic                 whi_en_q, whi_en_d;
    logic                 csn_prev_q;
    logic [7:0]           dq_q, dq_d;
    logic                 dq_oe_q, dq_oe_d, rwds_q, rwds_d, rwds_oe_q, rwds_oe_d;

    logic [15:0] mem [2**AddrWidth];
    logic [15:0] mem_rdata_q, rd_word;
    logic        mem_we_hi, mem_we_lo;
    logic [31:0] ca_addr;
    logic        unused_bits;

    assign ca_next     = ca_t'({ca_q[39:0], dq_s});
    assign ca_addr     = {ca_next.row, ca_next.col};
    assign rd_word     = ca_q.as ? ((addr_q == AddrWidth'(ID_ADDR)) ? IdReg0 : 16'h0000) : mem_rdata_q;
    assign unused_bits = ^{ca_q, ca_addr};

    always_comb begin
        state_d   = state_q;
        ca_d      = ca_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        lo_d      = lo_q;
        whi_d     = whi_q;
        whi_en_d  = whi_en_q;
        dq_d      = dq_q;
        dq_oe_d   = dq_oe_q;
        rwds_d    = rwds_q;
        rwds_oe_d = rwds_oe_q;
        mem_we_hi = 1'b0;
        mem_we_lo = 1'b0;
        if (state_q != IDLE && csn_s) begin
            state_d   = IDLE;
            dq_d      = 8'h00;
            dq_oe_d   = 1'b0;
            rwds_d    = 1'b0;
            rwds_oe_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (csn_prev_q && !csn_s) begin
                    state_d   = CA;
                    cnt_d     = '0;
                    rwds_d    = 1'b1;
                    rwds_oe_d = 1'b1;
                end
                CA: if (edge_s) begin
                    ca_d  = ca_next;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == CA_LAST) begin
                        cnt_d  = '0;
                        lo_d   = 1'b0;
                        addr_d = ca_addr[AddrWidth-1:0];
                        if (!ca_next.rw && ca_next.as) begin
                            state_d = REG_WR;
                        end else if (!ca_next.rw) begin
                            rwds_oe_d = 1'b0;
                            state_d   = LATENCY;
                        end else begin
                            rwds_d  = 1'b0;
                            state_d = LATENCY;
                        end
                    end
                end
                LATENCY: if (rising_s) begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == LAT_LAST) state_d = ca_q.rw ? RD_DATA : WR_DATA;
                end
                WR_DATA: if (edge_s) begin
                    lo_d = ~lo_q;
                    if (!lo_q) begin
                        whi_d    = dq_s;
                        whi_en_d = ~rwds_s;
                    end else begin
                        mem_we_hi = whi_en_q;
                        mem_we_lo = ~rwds_s;
                        addr_d    = addr_q + 1'b1;
                    end
                end
                RD_DATA: if (edge_s) begin
                    lo_d    = ~lo_q;
                    dq_oe_d = 1'b1;
                    rwds_d  = ~rwds_q;
                    if (!lo_q) begin
                        dq_d = rd_word[15:8];
                    end else begin
                        dq_d   = rd_word[7:0];
                        addr_d = addr_q + 1'b1;
                    end
                end
                REG_WR: if (edge_s) begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd1) state_d = WAIT_CSN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge arst) begin
        if (arst) begin
            state_q    <= IDLE;
            ca_q       <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            lo_q       <= 1'b0;
            whi_q      <= '0;
            whi_en_q   <= 1'b0;
            csn_prev_q <= 1'b1;
            dq_q       <= '0;
            dq_oe_q    <= 1'b0;
            rwds_q     <= 1'b0;
            rwds_oe_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ca_q       <= ca_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            lo_q       <= lo_d;
            whi_q      <= whi_d;
            whi_en_q   <= whi_en_d;
            csn_prev_q <= csn_s;
            dq_q       <= dq_d;
            dq_oe_q    <= dq_oe_d;
            rwds_q     <= rwds_d;
            rwds_oe_q  <= rwds_oe_d;
        end
    end

    // Synchronous read gives the one-cycle prefetch; an edge never follows within one clk_i.
    always_ff @(posedge clk_i) begin
        if (mem_we_hi) mem[addr_q][15:8] <= whi_q;
        if (mem_we_lo) mem[addr_q][7:0]  <= dq_s;
        mem_rdata_q <= mem[addr_q];
    end

    assign hyper_dq_o      = dq_q;
    assign hyper_dq_oe_o   = dq_oe_q;
    assign hyper_rwds_o    = rwds_q;
    assign hyper_rwds_oe_o = rwds_oe_q;

endmodule

// File: tb/tb_hyper_target_emu.sv
// Directed bench for hyper_target_emu: host-side HyperBus transactions with hand-computed expectations.
module tb_hyper_target_emu;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       hyper_reset_ni = 1'b1;
    logic       hyper_ck_i = 1'b0;
    logic       hyper_csn_i = 1'b1;
    logic [7:0] hyper_dq_i = 8'h00;
    logic       hyper_rwds_i = 1'b0;
    logic [7:0] hyper_dq_o;
    logic       hyper_dq_oe_o, hyper_rwds_o, hyper_rwds_oe_o;

    int n_checks = 0;
    int n_fails  = 0;

    logic [7:0]  s_dq;
    logic        s_rwds, s_dq_oe;
    logic [15:0] w;
    logic [1:0]  r;
    logic [47:0] ca;

    hyper_target_emu dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .hyper_reset_ni (hyper_reset_ni),
        .hyper_ck_i     (hyper_ck_i),
        .hyper_csn_i    (hyper_csn_i),
        .hyper_dq_i     (hyper_dq_i),
        .hyper_dq_o     (hyper_dq_o),
        .hyper_dq_oe_o  (hyper_dq_oe_o),
        .hyper_rwds_i   (hyper_rwds_i),
        .hyper_rwds_o   (hyper_rwds_o),
        .hyper_rwds_oe_o(hyper_rwds_oe_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] mk_ca(input logic rw, input logic as, input logic [9:0] a);
        logic [28:0] row;
        row = 29'(a >> 3);
        return {rw, as, 1'b1, row, 13'd0, a[2:0]};
    endfunction

    // One CK half period: drive dq/rwds, toggle CK, sample target outputs late in the half period.
    task automatic tick(input logic [7:0] d, input logic m);
        hyper_dq_i   = d;
        hyper_rwds_i = m;
        #20 hyper_ck_i = ~hyper_ck_i;
        #30;
        s_dq    = hyper_dq_o;
        s_rwds  = hyper_rwds_o;
        s_dq_oe = hyper_dq_oe_o;
        #10;
    endtask

    task automatic send_ca(input logic [47:0] c);
        hyper_csn_i = 1'b0;
        #40;
        for (int i = 5; i >= 0; i--) tick(c[i*8 +: 8], 1'b0);
    endtask

    task automatic latency();
        for (int i = 0; i < 23; i++) tick(8'h00, 1'b0);
    endtask

    task automatic finish_txn();
        #20 hyper_csn_i = 1'b1;
        #60 hyper_ck_i = 1'b0;
        #60;
    endtask

    task automatic wr_word(input logic [15:0] d, input logic mhi, input logic mlo);
        tick(d[15:8], mhi);
        tick(d[7:0], mlo);
    endtask

    task automatic rd_word(output logic [15:0] d, output logic [1:0] rw);
        tick(8'h00, 1'b0);
        d[15:8] = s_dq;
        rw[1]   = s_rwds;
        tick(8'h00, 1'b0);
        d[7:0]  = s_dq;
        rw[0]   = s_rwds;
    endtask

    initial begin
        rst_i = 1'b1;
        #20;
        check("rst_dq", {8'h00, hyper_dq_o}, 16'h0000);
        check("rst_dq_oe", {15'd0, hyper_dq_oe_o}, 16'd0);
        check("rst_rwds", {15'd0, hyper_rwds_o}, 16'd0);
        check("rst_rwds_oe", {15'd0, hyper_rwds_oe_o}, 16'd0);
        #20 rst_i = 1'b0;
        #40;

        // CK activity with csn high must be ignored
        for (int i = 0; i < 4; i++) tick(8'hA5, 1'b0);
        check("idle_oe", {14'd0, hyper_dq_oe_o, hyper_rwds_oe_o}, 16'd0);
        check("idle_dq", {8'h00, hyper_dq_o}, 16'h0000);
        hyper_ck_i = 1'b0;
        #60;

        // write 2 words at 0x010, read back
        send_ca(mk_ca(1'b0, 1'b0, 10'h010));
        check("wr_rwds_oe_drop", {15'd0, hyper_rwds_oe_o}, 16'd0);
        latency();
        wr_word(16'hA55A, 1'b0, 1'b0);
        wr_word(16'h1234, 1'b0, 1'b0);
        finish_txn();
        send_ca(mk_ca(1'b1, 1'b0, 10'h010));
        latency();
        rd_word(w, r);
        check("rd010_w0", w, 16'hA55A);
        check("rd010_rwds0", {14'd0, r}, 16'd2);
        rd_word(w, r);
        check("rd011_w1", w, 16'h1234);
        check("rd011_rwds1", {14'd0, r}, 16'd2);
        finish_txn();
        check("post_rd_oe", {14'd0, hyper_dq_oe_o, hyper_rwds_oe_o}, 16'd0);

        // masked low byte
        send_ca(mk_ca(1'b0, 1'b0, 10'h010));
        latency();
        wr_word(16'hFFFF, 1'b0, 1'b1);
        finish_txn();
        send_ca(mk_ca(1'b1, 1'b0, 10'h010));
        latency();
        rd_word(w, r);
        check("masked_wr", w, 16'hFF5A);
        finish_txn();

        // register read addr 0: rwds high through CA, data only after the 12th latency rising edge
        hyper_csn_i = 1'b0;
        #40;
        ca = mk_ca(1'b1, 1'b1, 10'h000);
        for (int i = 5; i >= 1; i--) begin
            tick(ca[i*8 +: 8], 1'b0);
            check("ca_rwds_hi", {14'd0, hyper_rwds_oe_o, s_rwds}, 16'd3);
        end
        tick(ca[7:0], 1'b0);
        check("rd_lat_rwds", {14'd0, hyper_rwds_oe_o, s_rwds}, 16'd2);
        for (int i = 0; i < 22; i++) tick(8'h00, 1'b0);
        check("lat_oe_11", {15'd0, s_dq_oe}, 16'd0);
        tick(8'h00, 1'b0);
        check("lat_oe_12", {15'd0, s_dq_oe}, 16'd0);
        rd_word(w, r);
        check("id_reg0", w, 16'h0C81);
        check("id_oe", {15'd0, hyper_dq_oe_o}, 16'd1);
        finish_txn();
        send_ca(mk_ca(1'b1, 1'b1, 10'h001));
        latency();
        rd_word(w, r);
        check("reg_addr1", w, 16'h0000);
        finish_txn();

        // register write is absorbed without touching memory
        send_ca(mk_ca(1'b0, 1'b1, 10'h010));
        tick(8'h8F, 1'b0);
        tick(8'hE7, 1'b0);
        tick(8'h00, 1'b0);
        finish_txn();

        // burst across the top of memory
        send_ca(mk_ca(1'b0, 1'b0, 10'h3FF));
        latency();
        wr_word(16'hBEEF, 1'b0, 1'b0);
        wr_word(16'hCAFE, 1'b0, 1'b0);
        wr_word(16'h5555, 1'b0, 1'b0);
        finish_txn();
        send_ca(mk_ca(1'b1, 1'b0, 10'h3FF));
        latency();
        rd_word(w, r);
        check("wrap_3ff", w, 16'hBEEF);
        rd_word(w, r);
        check("wrap_000", w, 16'hCAFE);
        rd_word(w, r);
        check("wrap_001", w, 16'h5555);
        finish_txn();
        send_ca(mk_ca(1'b1, 1'b0, 10'h010));
        latency();
        rd_word(w, r);
        check("regwr_no_mem", w, 16'hFF5A);
        finish_txn();

        // truncated write leaves 0x020 untouched
        send_ca(mk_ca(1'b0, 1'b0, 10'h020));
        latency();
        wr_word(16'h1111, 1'b0, 1'b0);
        finish_txn();
        send_ca(mk_ca(1'b0, 1'b0, 10'h020));
        latency();
        tick(8'h22, 1'b0);
        finish_txn();
        send_ca(mk_ca(1'b1, 1'b0, 10'h020));
        latency();
        rd_word(w, r);
        check("trunc_wr", w, 16'h1111);
        // truncated read: oe drops within 3 clk_i of csn rising
        tick(8'h00, 1'b0);
        check("trunc_rd_oe_before", {15'd0, hyper_dq_oe_o}, 16'd1);
        hyper_csn_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("trunc_rd_oe", {14'd0, hyper_dq_oe_o, hyper_rwds_oe_o}, 16'd0);
        #9 hyper_ck_i = 1'b0;
        #60;

        // bus reset mid-read: outputs cleared, memory kept
        send_ca(mk_ca(1'b1, 1'b0, 10'h011));
        latency();
        tick(8'h00, 1'b0);
        check("hrst_pre", {7'd0, s_dq_oe, s_dq}, 16'h0112);
        hyper_reset_ni = 1'b0;
        #1;
        check("hrst_out", {6'd0, hyper_dq_oe_o, hyper_rwds_oe_o, hyper_dq_o}, 16'h0000);
        #19 hyper_reset_ni = 1'b1;
        hyper_csn_i = 1'b1;
        hyper_ck_i  = 1'b0;
        #60;
        send_ca(mk_ca(1'b1, 1'b0, 10'h011));
        latency();
        rd_word(w, r);
        check("hrst_mem_kept", w, 16'h1234);

        // rst_i mid-read
        check("rst_pre_oe", {15'd0, hyper_dq_oe_o}, 16'd1);
        rst_i = 1'b1;
        #1;
        check("rst_mid_rd", {6'd0, hyper_dq_oe_o, hyper_rwds_oe_o, hyper_dq_o}, 16'h0000);
        check("rst_mid_rwds", {15'd0, hyper_rwds_o}, 16'd0);
        #19 rst_i = 1'b0;
        hyper_csn_i = 1'b1;
        hyper_ck_i  = 1'b0;
        #60;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
